cache_req_ctrl: RTL and testbench

- Request controller sitting directly upstream of memory_block; the only agent driving its control, key, value and index inputs.
- Accepts one GET/PUT/DEL request at a time over a valid/ready handshake.
- Sequences the key lookup, waits out memory_block's one-cycle registered result, then decides hit, miss, update, allocate or full.
- Issues any write/delete and returns one response over a valid/ready handshake.

---
 rtl/cache_cfg_pkg.sv | 6 +
 rtl/cache_ctrl_pkg.sv | 15 +
 rtl/cache_req_ctrl_free_slot_finder.sv | 15 +
 rtl/cache_req_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cache_req_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_cfg_pkg.sv
// Cache geometry shared by the controller and memory_block.
package cache_cfg_pkg;
   localparam int NUM_ENTRIES = 4;
   localparam int KEY_WIDTH   = 8;
   localparam int VALUE_WIDTH = 16;
endpackage

// File: rtl/cache_ctrl_pkg.sv
// Request controller types: opcodes, response status, FSM state encoding.
package cache_ctrl_pkg;
   localparam int STATUS_WIDTH = 2;
   localparam int OCC_WIDTH    = $clog2(cache_cfg_pkg::NUM_ENTRIES + 1);

   typedef enum logic [1:0] {OP_NOP = 2'd0, OP_GET = 2'd1, OP_PUT = 2'd2, OP_DEL = 2'd3} op_e;
   typedef enum logic [1:0] {ST_OK = 2'd0, ST_MISS = 2'd1, ST_FULL = 2'd2, ST_ERR = 2'd3} status_e;
   typedef enum logic [2:0] {
      CS_IDLE   = 3'd0,
      CS_LOOKUP = 3'd1,
      CS_EVAL   = 3'd2,
      CS_COMMIT = 3'd3,
      CS_RESP   = 3'd4
   } ctrl_state_e;
endpackage

// File: rtl/cache_req_ctrl_free_slot_finder.sv
// Lowest free cache slot as a one-hot, plus a found flag; purely combinational, no backpressure.
module free_slot_finder #(
   parameter int N = 4
) (
   input  logic [N-1:0] used_i,
   output logic [N-1:0] slot_o,
   output logic         found_o
);
   logic [N-1:0] free;

   assign free    = ~used_i;
   // Two's-complement trick isolates the lowest set bit of the free mask.
   assign slot_o  = free & (~free + N'(1));
   assign found_o = |free;
endmodule

// File: rtl/cache_req_ctrl.sv
// Sequences one GET/PUT/DEL at a time against memory_block; response after 1 (ERR), 3 or 4 cycles.
// Accepts only when idle; the response is held until resp_ready.
module cache_req_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int NUM_ENTRIES = cache_cfg_pkg::NUM_ENTRIES,
   parameter int KEY_WIDTH   = cache_cfg_pkg::KEY_WIDTH,
   parameter int VALUE_WIDTH = cache_cfg_pkg::VALUE_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [1:0]                         req_op,
   input  logic [KEY_WIDTH-1:0]               req_key,
   input  logic [VALUE_WIDTH-1:0]             req_value,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [STATUS_WIDTH-1:0]            resp_status,
   output logic [VALUE_WIDTH-1:0]             resp_value,
   output logic                               mem_write,
   output logic                               mem_delete,
   output logic                               mem_select_by_index,
   output logic [KEY_WIDTH-1:0]               mem_key,
   output logic [VALUE_WIDTH-1:0]             mem_value,
   output logic [NUM_ENTRIES-1:0]             mem_index,
   input  logic [VALUE_WIDTH-1:0]             mem_rd_value,
   input  logic [NUM_ENTRIES-1:0]             mem_rd_index,
   input  logic                               mem_hit,
   input  logic [NUM_ENTRIES-1:0]             mem_used,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);
   localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

   localparam logic [2:0] IDLE   = CS_IDLE;
   localparam logic [2:0] LOOKUP = CS_LOOKUP;
   localparam logic [2:0] EVAL   = CS_EVAL;
   localparam logic [2:0] COMMIT = CS_COMMIT;
   localparam logic [2:0] RESP   = CS_RESP;

   logic [2:0]             state_q, state_d;
   op_e                    op_q, op_d;
   logic [KEY_WIDTH-1:0]   key_q, key_d;
   logic [VALUE_WIDTH-1:0] value_q, value_d;
   logic [NUM_ENTRIES-1:0] target_q, target_d;
   status_e                status_q, status_d;
   logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;
   logic [OCC_W-1:0]       occ_q, occ_d;

   logic [NUM_ENTRIES-1:0] free_onehot;
   logic                   free_found;
   logic [NUM_ENTRIES-1:0] hit_onehot;

   free_slot_finder #(.N(NUM_ENTRIES)) u_free_slot (
      .used_i  (mem_used),
      .slot_o  (free_onehot),
      .found_o (free_found)
   );

   // Keep the write target one-hot even if the lookup ever reports several matches.
   assign hit_onehot = mem_rd_index & (~mem_rd_index + NUM_ENTRIES'(1));

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      key_d    = key_q;
      value_d  = value_q;
      target_d = target_q;
      status_d = status_q;
      rvalue_d = rvalue_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d     = op_e'(req_op);
               key_d    = req_key;
               value_d  = req_value;
               target_d = '0;
               rvalue_d = '0;
               if (req_op == OP_NOP || req_key == '0) begin
                  status_d = ST_ERR;
                  state_d  = RESP;
               end else begin
                  state_d  = LOOKUP;
               end
            end
         end
         LOOKUP: state_d = EVAL;
         EVAL: begin
            state_d = RESP;
            case (op_q)
               OP_GET: begin
                  status_d = mem_hit ? ST_OK : ST_MISS;
                  rvalue_d = mem_hit ? mem_rd_value : '0;
               end
               OP_PUT: begin
                  if (mem_hit) begin
                     target_d = hit_onehot;
                     state_d  = COMMIT;
                  end else if (free_found) begin
                     target_d = free_onehot;
                     state_d  = COMMIT;
                  end else begin
                     status_d = ST_FULL;
                  end
               end
               OP_DEL: begin
                  if (mem_hit) begin
                     target_d = hit_onehot;
                     state_d  = COMMIT;
                  end else begin
                     status_d = ST_MISS;
                  end
               end
               default: status_d = ST_ERR;
            endcase
         end
         COMMIT: begin
            status_d = ST_OK;
            state_d  = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_d  = IDLE;
               rvalue_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      occ_d = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         occ_d = occ_d + OCC_W'(mem_used[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= OP_NOP;
         key_q    <= '0;
         value_q  <= '0;
         target_q <= '0;
         status_q <= ST_OK;
         rvalue_q <= '0;
         occ_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         key_q    <= key_d;
         value_q  <= value_d;
         target_q <= target_d;
         status_q <= status_d;
         rvalue_q <= rvalue_d;
         occ_q    <= occ_d;
      end
   end

   // Everything below decodes registered state only, so reset forces all outputs low.
   assign req_ready           = rst_n && (state_q == IDLE);
   assign resp_valid          = (state_q == RESP);
   assign resp_status         = resp_valid ? status_q : '0;
   assign resp_value          = resp_valid ? rvalue_q : '0;
   assign mem_select_by_index = 1'b0;
   assign mem_key             = (state_q == LOOKUP || state_q == EVAL || state_q == COMMIT) ? key_q : '0;
   assign mem_write           = (state_q == COMMIT) && (op_q == OP_PUT);
   assign mem_delete          = (state_q == COMMIT) && (op_q == OP_DEL);
   assign mem_index           = (state_q == COMMIT) ? target_q : '0;
   assign mem_value           = mem_write ? value_q : '0;
   assign occupancy           = occ_q;
endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed bench for cache_req_ctrl against a small behavioural memory_block.
module tb_cache_req_ctrl;
   import cache_ctrl_pkg::*;

   localparam int NE = 4;
   localparam int KW = 8;
   localparam int VW = 16;

   logic          clk, rst_n, model_rst;
   logic          req_valid, req_ready, resp_valid, resp_ready;
   logic [1:0]    req_op, resp_status;
   logic [KW-1:0] req_key, mem_key;
   logic [VW-1:0] req_value, resp_value, mem_value, mem_rd_value;
   logic          mem_write, mem_delete, mem_select_by_index, mem_hit;
   logic [NE-1:0] mem_index, mem_rd_index, mem_used;
   logic [2:0]    occupancy;

   int pass_cnt = 0;
   int total    = 0;

   cache_req_ctrl #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_key(req_key), .req_value(req_value),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_status(resp_status), .resp_value(resp_value),
      .mem_write(mem_write), .mem_delete(mem_delete),
      .mem_select_by_index(mem_select_by_index),
      .mem_key(mem_key), .mem_value(mem_value), .mem_index(mem_index),
      .mem_rd_value(mem_rd_value), .mem_rd_index(mem_rd_index),
      .mem_hit(mem_hit), .mem_used(mem_used), .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory_block model: registered lookup, writes/deletes by one-hot index.
   logic [KW-1:0] m_key [NE];
   logic [VW-1:0] m_val [NE];
   logic [NE-1:0] m_used;
   assign mem_used = m_used;

   always @(posedge clk) begin : mdl
      logic          h;
      logic [NE-1:0] ix;
      logic [VW-1:0] v;
      h = 1'b0; ix = '0; v = '0;
      for (int i = 0; i < NE; i++) begin
         if (m_used[i] === 1'b1 && m_key[i] === mem_key) begin
            h = 1'b1; ix[i] = 1'b1; v = m_val[i];
         end
      end
      mem_hit      <= h;
      mem_rd_index <= ix;
      mem_rd_value <= v;
      if (model_rst) begin
         m_used <= '0;
      end else begin
         for (int i = 0; i < NE; i++) begin
            if (mem_write && mem_index[i]) begin
               m_key[i]  <= mem_key;
               m_val[i]  <= mem_value;
               m_used[i] <= 1'b1;
            end
            if (mem_delete && mem_index[i]) m_used[i] <= 1'b0;
         end
      end
   end

   int            wr_cnt = 0, del_cnt = 0, both_cnt = 0, multi_cnt = 0;
   logic [NE-1:0] wr_idx = '0, del_idx = '0;
   always @(posedge clk) begin
      if (mem_write) begin wr_cnt++; wr_idx = mem_index; end
      if (mem_delete) begin del_cnt++; del_idx = mem_index; end
      if (mem_write && mem_delete) both_cnt++;
      if ($countones(mem_index) > 1) multi_cnt++;
   end

   task automatic do_req(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                         output logic [1:0] st, output logic [VW-1:0] rv, output int lat,
                         output int nwr, output int ndel);
      int w0, d0;
      @(negedge clk);
      w0 = wr_cnt; d0 = del_cnt;
      req_op = op; req_key = key; req_value = val; req_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0; req_op = '0; req_key = '0; req_value = '0;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      st = resp_status; rv = resp_value;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      nwr = wr_cnt - w0; ndel = del_cnt - d0;
   endtask

   logic [1:0]    st;
   logic [VW-1:0] rv;
   int            lat, nwr, ndel;

   task automatic test_reset();
      rst_n = 1'b0; model_rst = 1'b1;
      req_valid = 1'b0; req_op = '0; req_key = '0; req_value = '0; resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if ({req_ready, resp_valid, mem_write, mem_delete} !== 4'b0) $display("FAIL reset_ctrl got %b exp 0000", {req_ready, resp_valid, mem_write, mem_delete}); else pass_cnt++;
      total++; if ({mem_key, mem_index, occupancy} !== '0) $display("FAIL reset_mem got %h exp 0", {mem_key, mem_index, occupancy}); else pass_cnt++;
      rst_n = 1'b1; model_rst = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else pass_cnt++;
   endtask

   task automatic test_put_get();
      do_req(OP_PUT, 8'h11, 16'hBEEF, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_OK || lat !== 4) $display("FAIL put_new got st=%0d lat=%0d exp st=0 lat=4", st, lat); else pass_cnt++;
      total++; if (nwr !== 1 || wr_idx !== 4'b0001) $display("FAIL put_new_wr got n=%0d idx=%b exp n=1 idx=0001", nwr, wr_idx); else pass_cnt++;
      total++; if (occupancy !== 3'd1) $display("FAIL put_new_occ got %0d exp 1", occupancy); else pass_cnt++;
      do_req(OP_GET, 8'h11, 16'h0, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_OK || rv !== 16'hBEEF || lat !== 3) $display("FAIL get_hit got st=%0d v=%h lat=%0d exp st=0 v=beef lat=3", st, rv, lat); else pass_cnt++;
      total++; if (nwr !== 0 || ndel !== 0) $display("FAIL get_no_wr got w=%0d d=%0d exp 0 0", nwr, ndel); else pass_cnt++;
   endtask

   task automatic test_update();
      do_req(OP_PUT, 8'h11, 16'h1234, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_OK || nwr !== 1 || wr_idx !== 4'b0001) $display("FAIL update got st=%0d n=%0d idx=%b exp st=0 n=1 idx=0001", st, nwr, wr_idx); else pass_cnt++;
      total++; if (occupancy !== 3'd1) $display("FAIL update_occ got %0d exp 1", occupancy); else pass_cnt++;
      do_req(OP_GET, 8'h11, 16'h0, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_OK || rv !== 16'h1234) $display("FAIL update_get got st=%0d v=%h exp st=0 v=1234", st, rv); else pass_cnt++;
   endtask

   task automatic test_fill();
      logic [NE-1:0] e;
      do_req(OP_DEL, 8'h11, 16'h0, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_OK || ndel !== 1 || del_idx !== 4'b0001 || occupancy !== 3'd0) $display("FAIL del_11 got st=%0d n=%0d idx=%b occ=%0d exp 0 1 0001 0", st, ndel, del_idx, occupancy); else pass_cnt++;
      for (int k = 1; k <= 4; k++) begin
         e = 4'b0001 << (k - 1);
         do_req(OP_PUT, 8'(k), 16'hA000 + 16'(k), st, rv, lat, nwr, ndel);
         total++; if (st !== ST_OK || nwr !== 1 || wr_idx !== e) $display("FAIL fill_%0d got st=%0d n=%0d idx=%b exp st=0 n=1 idx=%b", k, st, nwr, wr_idx, e); else pass_cnt++;
      end
      total++; if (occupancy !== 3'd4) $display("FAIL fill_occ got %0d exp 4", occupancy); else pass_cnt++;
      do_req(OP_PUT, 8'h05, 16'h5555, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_FULL || nwr !== 0 || lat !== 3) $display("FAIL put_full got st=%0d n=%0d lat=%0d exp st=2 n=0 lat=3", st, nwr, lat); else pass_cnt++;
   endtask

   task automatic test_delete_reuse();
      do_req(OP_DEL, 8'h02, 16'h0, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_OK || ndel !== 1 || del_idx !== 4'b0010 || lat !== 4) $display("FAIL del_2 got st=%0d n=%0d idx=%b lat=%0d exp 0 1 0010 4", st, ndel, del_idx, lat); else pass_cnt++;
      total++; if (occupancy !== 3'd3) $display("FAIL del_occ got %0d exp 3", occupancy); else pass_cnt++;
      do_req(OP_PUT, 8'h05, 16'h5555, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_OK || nwr !== 1 || wr_idx !== 4'b0010) $display("FAIL reuse got st=%0d n=%0d idx=%b exp st=0 n=1 idx=0010", st, nwr, wr_idx); else pass_cnt++;
      do_req(OP_GET, 8'h02, 16'h0, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_MISS || rv !== 16'h0 || lat !== 3) $display("FAIL get_deleted got st=%0d v=%h lat=%0d exp st=1 v=0 lat=3", st, rv, lat); else pass_cnt++;
      do_req(OP_GET, 8'h05, 16'h0, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_OK || rv !== 16'h5555) $display("FAIL get_5 got st=%0d v=%h exp st=0 v=5555", st, rv); else pass_cnt++;
   endtask

   task automatic test_err();
      do_req(OP_GET, 8'h00, 16'h0, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_ERR || lat !== 1 || nwr !== 0 || ndel !== 0) $display("FAIL err_key0 got st=%0d lat=%0d w=%0d d=%0d exp 3 1 0 0", st, lat, nwr, ndel); else pass_cnt++;
      do_req(OP_NOP, 8'h11, 16'h7777, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_ERR || lat !== 1 || nwr !== 0 || ndel !== 0) $display("FAIL err_nop got st=%0d lat=%0d w=%0d d=%0d exp 3 1 0 0", st, lat, nwr, ndel); else pass_cnt++;
      do_req(OP_DEL, 8'h77, 16'h0, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_MISS || lat !== 3 || ndel !== 0) $display("FAIL del_miss got st=%0d lat=%0d d=%0d exp 1 3 0", st, lat, ndel); else pass_cnt++;
   endtask

   task automatic test_stall();
      int n;
      @(negedge clk);
      req_op = OP_GET; req_key = 8'h01; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_op = '0; req_key = '0;
      n = 0;
      while (!resp_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
      total++; if (resp_valid !== 1'b1) $display("FAIL stall_resp got %b exp 1", resp_valid); else pass_cnt++;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         total++; if (resp_valid !== 1'b1 || resp_status !== ST_OK || resp_value !== 16'hA001 || req_ready !== 1'b0) $display("FAIL stall_hold_%0d got v=%b st=%0d val=%h rdy=%b exp 1 0 a001 0", c, resp_valid, resp_status, resp_value, req_ready); else pass_cnt++;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      total++; if (resp_valid !== 1'b0 || resp_value !== 16'h0 || req_ready !== 1'b1) $display("FAIL stall_release got v=%b val=%h rdy=%b exp 0 0 1", resp_valid, resp_value, req_ready); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int d0;
      @(negedge clk);
      d0 = del_cnt;
      req_op = OP_DEL; req_key = 8'h03; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_op = '0; req_key = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (mem_delete !== 1'b1 || mem_index !== 4'b0100) $display("FAIL mid_commit got d=%b idx=%b exp 1 0100", mem_delete, mem_index); else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total++; if ({req_ready, resp_valid, mem_write, mem_delete, mem_select_by_index} !== 5'b0 || {mem_key, mem_index, mem_value, resp_status, resp_value, occupancy} !== '0) $display("FAIL mid_outputs got %b %h exp all 0", {req_ready, resp_valid, mem_write, mem_delete}, {mem_key, mem_index, mem_value, resp_status, resp_value, occupancy}); else pass_cnt++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1 || del_cnt !== d0) $display("FAIL mid_idle got rdy=%b dels=%0d exp 1 %0d", req_ready, del_cnt, d0); else pass_cnt++;
      do_req(OP_GET, 8'h03, 16'h0, st, rv, lat, nwr, ndel);
      total++; if (st !== ST_OK || rv !== 16'hA003 || occupancy !== 3'd4) $display("FAIL mid_survive got st=%0d v=%h occ=%0d exp 0 a003 4", st, rv, occupancy); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_put_get();
      test_update();
      test_fill();
      test_delete_reuse();
      test_err();
      test_stall();
      test_reset_mid();
      total++; if (both_cnt !== 0 || multi_cnt !== 0) $display("FAIL mem_exclusive got both=%0d multi=%0d exp 0 0", both_cnt, multi_cnt); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
